// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces the
// column response, and emits a one-cycle valid strobe with the accepted key code.
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] code,
    output logic       valid,
    output logic       key_down
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t             state, state_n;
    logic [3:0]         col_meta, col_s;
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         row_idx, row_idx_n;
    logic [DEB_W-1:0]   deb_cnt, deb_cnt_n, deb_inc;
    logic [3:0]         cand, cand_n;
    logic [3:0]         code_n;
    logic               valid_n, key_down_n;
    logic               sample, single, idle;
    logic [1:0]         col_idx;

    assign row     = ~(4'b0001 << row_idx);
    assign sample  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign idle    = (col_s == 4'b1111);
    assign deb_inc = deb_cnt + 1'b1;

    always_comb begin
        single  = 1'b1;
        col_idx = 2'd0;
        unique case (col_s)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: single  = 1'b0;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which is what would otherwise infer a latch.
    always_comb begin
        state_n    = state;
        row_idx_n  = row_idx;
        deb_cnt_n  = deb_cnt;
        cand_n     = cand;
        code_n     = code;
        valid_n    = 1'b0;
        key_down_n = key_down;

        if (sample) begin
            unique case (state)
                SCAN: begin
                    if (single) begin
                        if (DEBOUNCE_CNT == 1) begin
                            code_n     = {row_idx, col_idx};
                            valid_n    = 1'b1;
                            key_down_n = 1'b1;
                            deb_cnt_n  = '0;
                            state_n    = HELD;
                        end else begin
                            cand_n    = {row_idx, col_idx};
                            deb_cnt_n = DEB_W'(1);
                            state_n   = DEBOUNCE;
                        end
                    end else begin
                        row_idx_n = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single && (col_idx == cand[1:0])) begin
                        if (deb_inc == DEB_W'(DEBOUNCE_CNT)) begin
                            code_n     = cand;
                            valid_n    = 1'b1;
                            key_down_n = 1'b1;
                            deb_cnt_n  = '0;
                            state_n    = HELD;
                        end else begin
                            deb_cnt_n = deb_inc;
                        end
                    end else begin
                        // Bounce or a changed key: abandon the candidate silently.
                        deb_cnt_n = '0;
                        row_idx_n = row_idx + 2'd1;
                        state_n   = SCAN;
                    end
                end
                HELD: begin
                    if (idle) begin
                        if (deb_inc == DEB_W'(DEBOUNCE_CNT)) begin
                            key_down_n = 1'b0;
                            deb_cnt_n  = '0;
                            row_idx_n  = row_idx + 2'd1;
                            state_n    = SCAN;
                        end else begin
                            deb_cnt_n = deb_inc;
                        end
                    end else begin
                        deb_cnt_n = '0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
            div_cnt  <= '0;
            row_idx  <= 2'd0;
            deb_cnt  <= '0;
            cand     <= 4'h0;
            code     <= 4'h0;
            valid    <= 1'b0;
            key_down <= 1'b0;
            state    <= SCAN;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
            div_cnt  <= sample ? '0 : div_cnt + 1'b1;
            row_idx  <= row_idx_n;
            deb_cnt  <= deb_cnt_n;
            cand     <= cand_n;
            code     <= code_n;
            valid    <= valid_n;
            key_down <= key_down_n;
            state    <= state_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives col from row, and a
// scoreboard of expected key codes is consumed by the valid/code hand-off.
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] code;
    logic       valid;
    logic       key_down;

    logic [15:0] keys = 16'h0000;
    logic [3:0]  sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          valid_cnt = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .col      (col),
        .row      (row),
        .code     (code),
        .valid    (valid),
        .key_down (key_down)
    );

    always #5 clock = ~clock;

    // Pressed key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decoder side of the hand-off: each rd_enable pulse consumes one expected code.
    always @(negedge clock) begin
        if (reset_n && valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                check("spurious_valid", {7'b0, valid}, 8'h00);
            end else begin
                check("handoff_code", {4'h0, code}, {4'h0, sb.pop_front()});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Returns at the first negedge after row switches onto target.
    task automatic wait_row_entry(input logic [3:0] target);
        int n = 0;
        while (row == target && n < 100) begin @(negedge clock); n++; end
        while (row != target && n < 100) begin @(negedge clock); n++; end
        check("row_entry", {4'h0, row}, {4'h0, target});
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (valid !== 1'b1 && n < max) begin @(negedge clock); n++; end
        check(tag, {7'b0, valid}, 8'h01);
    endtask

    task automatic wait_release(input string tag, input int max);
        int n = 0;
        while (key_down !== 1'b0 && n < max) begin @(negedge clock); n++; end
        check(tag, {7'b0, key_down}, 8'h00);
    endtask

    initial begin
        int vc;

        // 1: col2 held on row0 from reset; valid exactly at edge 12, never again.
        keys[2] = 1'b1;
        cyc(2);
        check("rst_row", {4'h0, row}, 8'h0E);
        check("rst_code", {4'h0, code}, 8'h00);
        check("rst_valid", {7'b0, valid}, 8'h00);
        check("rst_key_down", {7'b0, key_down}, 8'h00);
        sb.push_back(4'h2);
        reset_n = 1'b1;
        cyc(11);
        check("t1_no_early_valid", {7'b0, valid}, 8'h00);
        cyc(1);
        check("t1_valid_edge12", {7'b0, valid}, 8'h01);
        check("t1_code", {4'h0, code}, 8'h02);
        check("t1_key_down", {7'b0, key_down}, 8'h01);
        cyc(1);
        check("t1_valid_one_cycle", {7'b0, valid}, 8'h00);
        cyc(200);
        check("t1_single_pulse", 8'(valid_cnt), 8'd1);
        check("t1_row_frozen", {4'h0, row}, 8'h0E);
        check("t1_still_held", {7'b0, key_down}, 8'h01);

        // 4: release, then row3/col1.
        keys = 16'h0000;
        wait_release("t4_key_down_fall", 30);
        check("t4_row_advanced", {4'h0, row}, 8'h0D);
        sb.push_back(4'hD);
        keys[13] = 1'b1;
        wait_valid("t4_valid_seen", 80);
        cyc(1);
        check("t4_code", {4'h0, code}, 8'h0D);
        check("t4_key_down", {7'b0, key_down}, 8'h01);
        keys = 16'h0000;
        wait_release("t4_release2", 30);

        // 2: bounce, two matching samples then idle.
        vc = valid_cnt;
        wait_row_entry(4'b1110);
        keys[2] = 1'b1;
        cyc(8);
        check("t2_row_frozen", {4'h0, row}, 8'h0E);
        keys = 16'h0000;
        cyc(4);
        check("t2_row_advance", {4'h0, row}, 8'h0D);
        check("t2_no_valid", 8'(valid_cnt - vc), 8'd0);
        check("t2_no_key_down", {7'b0, key_down}, 8'h00);

        // 3: two columns at once on row0, row keeps cycling.
        wait_row_entry(4'b1110);
        keys[1] = 1'b1;
        keys[2] = 1'b1;
        cyc(4);  check("t3_row1", {4'h0, row}, 8'h0D);
        cyc(4);  check("t3_row2", {4'h0, row}, 8'h0B);
        cyc(4);  check("t3_row3", {4'h0, row}, 8'h07);
        cyc(4);  check("t3_wrap", {4'h0, row}, 8'h0E);
        cyc(4);  check("t3_row1_again", {4'h0, row}, 8'h0D);
        check("t3_no_valid", 8'(valid_cnt - vc), 8'd0);
        keys = 16'h0000;

        // 5: reset in the middle of debouncing.
        wait_row_entry(4'b1110);
        keys[2] = 1'b1;
        cyc(8);
        reset_n = 1'b0;
        #1;
        check("t5_rst_row", {4'h0, row}, 8'h0E);
        check("t5_rst_code", {4'h0, code}, 8'h00);
        check("t5_rst_valid", {7'b0, valid}, 8'h00);
        check("t5_rst_key_down", {7'b0, key_down}, 8'h00);
        cyc(1);
        sb.push_back(4'h2);
        reset_n = 1'b1;
        cyc(11);
        check("t5_no_early_valid", {7'b0, valid}, 8'h00);
        cyc(1);
        check("t5_valid_full_debounce", {7'b0, valid}, 8'h01);
        keys = 16'h0000;
        wait_release("t5_release", 30);

        // 6: decoder hand-off, one pulse per press.
        vc = valid_cnt;
        sb.push_back(4'h2);
        keys[2] = 1'b1;
        wait_valid("t6_valid_2", 80);
        cyc(1);
        keys = 16'h0000;
        wait_release("t6_release_2", 30);
        sb.push_back(4'hD);
        keys[13] = 1'b1;
        wait_valid("t6_valid_D", 80);
        cyc(1);
        keys = 16'h0000;
        wait_release("t6_release_D", 30);
        cyc(20);
        check("t6_pulse_count", 8'(valid_cnt - vc), 8'd2);
        check("sb_drained", 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Upstream stage of the keypad decoder. It scans a 4x4 matrix keypad by driving rows low one at a time and sampling the column lines. It debounces press and release, then presents a 4-bit key code together with a one-cycle valid strobe. The valid strobe connects directly to the decoder's rd_enable input, and code connects to the decoder's code input.

Parameters:
SCAN_DIV, 4, clock cycles each row is driven before its columns are sampled (minimum 3, to cover synchroniser latency)
DEBOUNCE_CNT, 3, number of consecutive identical samples needed to accept a press or a release (minimum 1)

Ports:
clock  input  1  system clock; every register updates on its rising edge
reset_n  input  1  reset, asynchronous and active-low
col  input  4  keypad column lines, active-low with external pull-ups, asynchronous to clock
row  output  4  keypad row drive, active-low, exactly one bit low at any time
code  output  4  last accepted key, code = row_idx*4 + col_idx
valid  output  1  one-cycle pulse when a new debounced key is accepted (drives decoder rd_enable)
key_down  output  1  high while the accepted key is still held (HELD state)

Behaviour:
- Reset values (async, while reset_n=0): row=4'b1110, row_idx=0, div_cnt=0, deb_cnt=0, cand=0, code=4'h0, valid=0, key_down=0, state=SCAN, synchroniser flops=4'b1111.
- col passes through a 2-flop synchroniser to give col_s. Only col_s is used internally.
- div_cnt counts 0..SCAN_DIV-1 and wraps. A "sample" occurs on the edge where div_cnt==SCAN_DIV-1.
- row = ~(4'b0001 << row_idx). It changes only when row_idx advances, and row_idx wraps 3 -> 0.
- A sample is "single" when col_s has exactly one zero bit; col_idx is that bit's position. A sample is "idle" when col_s==4'b1111. Any other value is "multi".
- State SCAN:
  - Single sample: cand <= {row_idx, col_idx}, deb_cnt <= 1, row held, go to DEBOUNCE. If DEBOUNCE_CNT==1, accept immediately instead (see accept below).
  - Idle or multi sample: row_idx advances.
- State DEBOUNCE (row frozen):
  - Single sample with the same col_idx: deb_cnt increments.
  - When deb_cnt reaches DEBOUNCE_CNT, accept: code <= cand, valid <= 1 for exactly one cycle, key_down <= 1, deb_cnt <= 0, go to HELD.
  - Any other sample (idle, multi, or a different column): deb_cnt <= 0, row_idx advances, go to SCAN. No valid is produced.
- State HELD (row frozen; valid=0):
  - Idle sample: deb_cnt increments.
  - Non-idle sample: deb_cnt <= 0. Extra keys pressed while held are ignored.
  - When deb_cnt reaches DEBOUNCE_CNT: key_down <= 0, deb_cnt <= 0, row_idx advances, go to SCAN.
- code holds its value until the next accept. A held key never produces a second valid.
- Latency: with a key stable before reset release on row 0, valid is registered high by rising edge DEBOUNCE_CNT*SCAN_DIV after release. With defaults this is edge 12, high during cycle 12 only.
- Reset asserted mid-operation: all registers return to their reset values immediately. No valid is issued for a partially debounced key.
- Keys on other rows are invisible until their row is driven. Worst-case scan delay before the first sample of a key is 4*SCAN_DIV cycles.

Test Plan:
1. Defaults; col=4'b1011 (col2) held from reset while row=1110 -> one valid pulse at edge 12, code=4'h2, key_down=1; no second pulse over 200 cycles held.
2. Bounce: col2 on row0 pressed for only 2 samples, then idle -> valid never asserts; row advances to 4'b1101 and scanning continues.
3. Multi: col=4'b1001 on row0 -> no valid, no DEBOUNCE entry; row cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110 (wrap).
4. Release then new key: release the test 1 key -> key_down falls after 3 idle samples; then press row3/col1 (col=4'b1101 while row=0111) -> valid pulse, code=4'hD.
5. Reset mid-DEBOUNCE: assert reset_n=0 after 2 matching samples -> row=1110, code=0, valid=0, key_down=0 asynchronously; after release, a stable key is accepted only after a full DEBOUNCE_CNT samples.
6. Hand-off: connect valid and code to the decoder -> press keys 4'h2 then 4'hD -> decoder rd_enable sees exactly one pulse per press with the matching code.
